seq_gen_serial: RTL and testbench
=================================

// Module: seq_gen_serial
// PURPOSE
//   Bit-serial pattern transmitter; the stimulus end of the serial sequence-detect path.
//   Accepts a pattern word through a valid/ready handshake.
//   Shifts the pattern out one bit per clock on seq_out, MSB of the active field first.
//   Optionally repeats the word with idle gap cycles between copies.
//   Drives the detector input in loopback benches and in-system self-test.
// PARAMETERS
//   MAX_LEN     16  max pattern length in bits (>=2)
//   LEN_W       4   width of pat_len = $clog2(MAX_LEN)
//   RPT_W       4   width of pat_repeat
//   GAP_CYCLES  2   idle cycles between repeated copies (0 = back-to-back)
//   IDLE_LVL    1'b0 level driven on seq_out when not transmitting
// PORTS
//   clk         in   1        rising-edge clock
//   rst_n       in   1        asynchronous active-low reset
//   pat_valid   in   1        pattern word offered
//   pat_ready   out  1        block can accept a word (high only in IDLE)
//   pat_data    in   MAX_LEN  pattern; bits [pat_len:0] used, upper bits ignored
//   pat_len     in   LEN_W    pattern length minus one (0 -> 1 bit)
//   pat_repeat  in   RPT_W    extra copies after the first (0 -> sent once)
//   abort       in   1        synchronous abort, any state
//   seq_out     out  1        serial data bit
//   seq_valid   out  1        seq_out carries a pattern bit this cycle
//   frame_start out  1        high with the first bit of every copy
//   done        out  1        1-cycle pulse after the last bit of the last copy
//   state_out   out  2        current FSM state (debug)
// BEHAVIOUR
//   Outputs and reset
//   - All outputs are registered.
//   - Asynchronous reset (any time, including mid-word) forces:
//     state=IDLE, seq_out=IDLE_LVL, seq_valid=0, frame_start=0, done=0.
//   - pat_ready=1 out of reset.
//   FSM encoding (2 bits)
//   - IDLE=00, SHIFT=01, GAP=10, DONE=11.
//   Acceptance
//   - IDLE: pat_ready=1. Handshake = pat_valid&&pat_ready at posedge T.
//   - At edge T: capture data, len and repeat; set bit index idx=pat_len.
//   - At edge T: state->SHIFT, seq_out=pat_data[pat_len], seq_valid=1, frame_start=1.
//   - Latency: first bit is visible in the cycle after edge T.
//   - pat_valid outside IDLE is ignored, since pat_ready=0; no buffering.
//   Shifting
//   - SHIFT: each edge, idx--, seq_out=data[idx], frame_start=0.
//   - Copy length is exactly pat_len+1 cycles with seq_valid=1.
//   - After bit 0, if rpt_cnt>0: rpt_cnt--.
//     If GAP_CYCLES>0: enter GAP for exactly GAP_CYCLES cycles.
//     If GAP_CYCLES=0: re-enter SHIFT with idx=len, frame_start=1, no bubble.
//   - After bit 0, if rpt_cnt==0: enter DONE.
//   GAP and DONE
//   - GAP: seq_out=IDLE_LVL, seq_valid=0.
//     On expiry the first bit of the next copy follows directly, with frame_start=1.
//   - DONE: done=1 for one cycle, seq_valid=0. Next edge returns to IDLE with pat_ready=1.
//   - A new word cannot be accepted in the DONE cycle.
//   Boundary conditions
//   - pat_len=0: each copy is a single cycle, and frame_start is high on it.
//   - pat_repeat at max (2^RPT_W-1): sends 2^RPT_W copies. The counter must not wrap.
//   - abort: next edge state->IDLE, seq_out=IDLE_LVL, seq_valid=0, no done pulse.
//     abort has priority over a same-cycle handshake; in IDLE, abort blocks acceptance.
// STRUCTURE
//   - seq_pkg holds: state localparams (ST_IDLE..ST_DONE), default IDLE_LVL.
//   - seq_pkg also holds helper function clog2 for LEN_W.
//   - Sub-module seq_gap_timer: loadable down-counter with an expiry flag, used for GAP.
//   - Shift index, repeat counter and FSM stay in seq_gen_serial.
// TESTING
//   - Reset: rst_n=0 for 2.5us mid-clock -> all outputs at reset values, pat_ready=1.
//   - Single word: data=4'b1010, len=3, rpt=0 -> seq_out 1,0,1,0.
//     seq_valid high 4 cycles, frame_start on the first bit, done next cycle, IDLE after.
//   - Repeat+gap: data=3'b110, len=2, rpt=2, GAP=2 -> 110,gap,gap,110,gap,gap,110.
//     Expect 3 frame_start pulses and a single done.
//   - Back-to-back: GAP=0, data=2'b01, len=1, rpt=3 -> 01010101 with no bubbles.
//     Loopback into the overlapping detector yields the expected hit count.
//   - Abort and reset mid-word: abort on bit 2 of a 16-bit word -> IDLE next edge, no done.
//     Then rst_n low mid-SHIFT -> immediate outputs-idle.
//   - Handshake edges: pat_valid held during SHIFT is not accepted.
//     len=0, rpt=0 -> 1-cycle word. Abort with pat_valid in IDLE -> not accepted.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial pattern generator.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam logic IDLE_LVL_DEF = 1'b0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/seq_gap_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module seq_gap_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/seq_gen_serial.sv
// Bit-serial pattern transmitter: MSB-first shift-out with optional
// repeated copies separated by idle gap cycles.
module seq_gen_serial
    import seq_pkg::*;
#(
    parameter int   MAX_LEN    = 16,
    parameter int   LEN_W      = clog2(MAX_LEN),
    parameter int   RPT_W      = 4,
    parameter int   GAP_CYCLES = 2,
    parameter logic IDLE_LVL   = IDLE_LVL_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pat_valid,
    output logic               pat_ready,
    input  logic [MAX_LEN-1:0] pat_data,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic [RPT_W-1:0]   pat_repeat,
    input  logic               abort,
    output logic               seq_out,
    output logic               seq_valid,
    output logic               frame_start,
    output logic               done,
    output logic [1:0]         state_out
);

    // Timer holds GAP_CYCLES-1 so expiry lands in the last gap cycle.
    localparam int GAP_W = (GAP_CYCLES > 1) ? clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD =
        GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t               state_q, state_d;
    logic [MAX_LEN-1:0]   data_q, data_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     idx_q, idx_d;
    logic [RPT_W-1:0]     rpt_q, rpt_d;
    logic                 out_d, valid_d, fs_d, done_d, ready_d;
    logic                 gap_load, gap_expired;

    seq_gap_timer #(.W(GAP_W)) u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .expired  (gap_expired)
    );

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        len_d    = len_q;
        idx_d    = idx_q;
        rpt_d    = rpt_q;
        out_d    = IDLE_LVL;
        valid_d  = 1'b0;
        fs_d     = 1'b0;
        done_d   = 1'b0;
        gap_load = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pat_valid) begin
                        data_d  = pat_data;
                        len_d   = pat_len;
                        idx_d   = pat_len;
                        rpt_d   = pat_repeat;
                        state_d = ST_SHIFT;
                        out_d   = pat_data[pat_len];
                        valid_d = 1'b1;
                        fs_d    = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (idx_q != '0) begin
                        idx_d   = idx_q - LEN_W'(1);
                        out_d   = data_q[idx_d];
                        valid_d = 1'b1;
                    end else if (rpt_q != '0) begin
                        rpt_d = rpt_q - RPT_W'(1);
                        if (GAP_CYCLES > 0) begin
                            state_d  = ST_GAP;
                            gap_load = 1'b1;
                        end else begin
                            idx_d   = len_q;
                            out_d   = data_q[len_q];
                            valid_d = 1'b1;
                            fs_d    = 1'b1;
                        end
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_expired) begin
                        state_d = ST_SHIFT;
                        idx_d   = len_q;
                        out_d   = data_q[len_q];
                        valid_d = 1'b1;
                        fs_d    = 1'b1;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            data_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            rpt_q       <= '0;
            seq_out     <= IDLE_LVL;
            seq_valid   <= 1'b0;
            frame_start <= 1'b0;
            done        <= 1'b0;
            pat_ready   <= 1'b1;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            rpt_q       <= rpt_d;
            seq_out     <= out_d;
            seq_valid   <= valid_d;
            frame_start <= fs_d;
            done        <= done_d;
            pat_ready   <= ready_d;
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_seq_gen_serial.sv
// Directed, table-driven bench for seq_gen_serial (gap=2 and gap=0 builds).
module tb_seq_gen_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pv = 1'b0;
    logic        pv0 = 1'b0;
    logic [15:0] pdata = '0;
    logic [3:0]  plen = '0;
    logic [3:0]  prpt = '0;
    logic        abort = 1'b0;

    logic        rdy, sout, sval, fs, dn;
    logic [1:0]  st;
    logic        rdy0, sout0, sval0, fs0, dn0;
    logic [1:0]  st0;

    int total = 0;
    int bad = 0;
    int hits;
    logic [3:0] hist;

    always #5 clk = ~clk;

    seq_gen_serial #(.GAP_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .pat_valid(pv), .pat_ready(rdy),
        .pat_data(pdata), .pat_len(plen), .pat_repeat(prpt), .abort(abort),
        .seq_out(sout), .seq_valid(sval), .frame_start(fs), .done(dn),
        .state_out(st)
    );

    seq_gen_serial #(.GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .pat_valid(pv0), .pat_ready(rdy0),
        .pat_data(pdata), .pat_len(plen), .pat_repeat(prpt), .abort(abort),
        .seq_out(sout0), .seq_valid(sval0), .frame_start(fs0), .done(dn0),
        .state_out(st0)
    );

    // Cycle code -> {ready, state, valid, out, frame_start, done}
    function automatic logic [6:0] exp_of(input byte c);
        case (c)
            "0":     return 7'b0_01_1_0_0_0;
            "1":     return 7'b0_01_1_1_0_0;
            "A":     return 7'b0_01_1_0_1_0;
            "B":     return 7'b0_01_1_1_1_0;
            "g":     return 7'b0_10_0_0_0_0;
            "d":     return 7'b0_11_0_0_0_1;
            default: return 7'b1_00_0_0_0_0;
        endcase
    endfunction

    function automatic logic [6:0] obs(input bit sel);
        if (sel) return {rdy0, st0, sval0, sout0, fs0, dn0};
        return {rdy, st, sval, sout, fs, dn};
    endfunction

    task automatic check_cyc(input bit sel, input byte c,
                             input string tag, input int i);
        logic [6:0] got, want;
        got  = obs(sel);
        want = exp_of(c);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc %0d: got %b want %b", tag, i, got, want);
        end
    endtask

    task automatic start(input bit sel, input logic [15:0] d,
                         input logic [3:0] l, input logic [3:0] r);
        @(negedge clk);
        pdata = d;
        plen  = l;
        prpt  = r;
        if (sel) pv0 = 1'b1;
        else pv = 1'b1;
        @(negedge clk);
        pv  = 1'b0;
        pv0 = 1'b0;
    endtask

    task automatic run_vec(input bit sel, input logic [15:0] d,
                           input logic [3:0] l, input logic [3:0] r,
                           input string exp, input string tag);
        hits = 0;
        hist = 4'b1111;
        start(sel, d, l, r);
        for (int i = 0; i < exp.len(); i++) begin
            check_cyc(sel, exp[i], tag, i);
            if (sel && sval0) begin
                hist = {hist[2:0], sout0};
                if (hist == 4'b0101) hits++;
            end
            @(negedge clk);
        end
    endtask

    typedef struct packed {
        logic        sel;
        logic [15:0] d;
        logic [3:0]  l;
        logic [3:0]  r;
    } vec_t;

    localparam int NV = 7;
    vec_t  vin[NV];
    string vexp[NV];

    initial begin
        string s;
        s = "";
        for (int k = 0; k < 15; k++) s = {s, "Bgg"};
        s = {s, "Bdi"};

        vin[0] = '{1'b0, 16'h000A, 4'd3, 4'd0};  vexp[0] = "B010di";
        vin[1] = '{1'b0, 16'h0006, 4'd2, 4'd2};  vexp[1] = "B10ggB10ggB10di";
        vin[2] = '{1'b0, 16'hFFFE, 4'd0, 4'd0};  vexp[2] = "Adi";
        vin[3] = '{1'b0, 16'h0000, 4'd0, 4'd1};  vexp[3] = "AggAdi";
        vin[4] = '{1'b0, 16'h8001, 4'd15, 4'd0};
        vexp[4] = {"B", "0000000", "0000000", "1di"};
        vin[5] = '{1'b0, 16'h0001, 4'd0, 4'd15}; vexp[5] = s;
        vin[6] = '{1'b1, 16'hFFF1, 4'd1, 4'd3};  vexp[6] = "A1A1A1A1di";

        // Reset held low 2.5us, released mid-clock
        #2500;
        check_cyc(1'b0, "i", "reset", 0);
        check_cyc(1'b1, "i", "reset0", 0);
        #2;
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < NV; k++) begin
            run_vec(vin[k].sel, vin[k].d, vin[k].l, vin[k].r,
                    vexp[k], $sformatf("vec%0d", k));
        end
        total++;
        if (hits != 3) begin
            bad++;
            $display("FAIL loopback_hits: got %0d want 3", hits);
        end

        // pat_valid held through the word with changed data
        start(1'b0, 16'h000A, 4'd3, 4'd0);
        pv = 1'b1;
        pdata = 16'h0005;
        check_cyc(1'b0, "B", "held", 0);
        @(negedge clk); check_cyc(1'b0, "0", "held", 1);
        @(negedge clk); check_cyc(1'b0, "1", "held", 2);
        @(negedge clk); check_cyc(1'b0, "0", "held", 3);
        @(negedge clk); check_cyc(1'b0, "d", "held", 4);
        @(negedge clk); check_cyc(1'b0, "i", "held", 5);
        pv = 1'b0;
        @(negedge clk); check_cyc(1'b0, "i", "held", 6);

        // Abort on the third bit of a 16-bit word
        start(1'b0, 16'hFFFF, 4'd15, 4'd0);
        check_cyc(1'b0, "B", "abort", 0);
        @(negedge clk); check_cyc(1'b0, "1", "abort", 1);
        @(negedge clk); check_cyc(1'b0, "1", "abort", 2);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_cyc(1'b0, "i", "abort", 3);
        @(negedge clk); check_cyc(1'b0, "i", "abort", 4);

        // Abort with a same-cycle handshake in IDLE
        pv = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        pv = 1'b0;
        abort = 1'b0;
        check_cyc(1'b0, "i", "abort_idle", 0);
        @(negedge clk); check_cyc(1'b0, "i", "abort_idle", 1);

        // Asynchronous reset mid-SHIFT
        start(1'b0, 16'hFFFF, 4'd15, 4'd0);
        check_cyc(1'b0, "B", "rst_mid", 0);
        @(negedge clk); check_cyc(1'b0, "1", "rst_mid", 1);
        #2 rst_n = 1'b0;
        #1 check_cyc(1'b0, "i", "rst_mid", 2);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); check_cyc(1'b0, "i", "rst_mid", 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
